// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
// Optional signed-overflow output is enabled with CSA_OVERFLOW_EN.
package csa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int csa_num_blocks(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select slice: both carry-in outcomes precomputed, then selected.
// With CSA_OVERFLOW_EN the carry into the slice's top bit is also exported.
module csa_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             msb_cin
`endif
);

    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;

    assign r0 = {1'b0, a} + {1'b0, b};
    assign r1 = {1'b0, a} + {1'b0, b} + (BLOCK+1)'(1);

    assign {cout, sum} = cin ? r1 : r0;

`ifdef CSA_OVERFLOW_EN
    // Top-bit sum = a ^ b ^ carry_in, so the carry in is recoverable.
    assign msb_cin = a[BLOCK-1] ^ b[BLOCK-1] ^ sum[BLOCK-1];
`endif

endmodule

// File: rtl/carry_select_adder_pipe.sv
// Pipelined carry-select adder/subtractor, one register stage per slice.
// Define CSA_OVERFLOW_EN to add the registered signed Overflow output.
module carry_select_adder_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int NB = csa_num_blocks(WIDTH, BLOCK);

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic             v_q  [NB];
    logic             c_q  [NB];
    logic [WIDTH-1:0] a_q  [NB];
    logic [WIDTH-1:0] b_q  [NB];
    logic [WIDTH-1:0] s_q  [NB];

    logic             v_nx [NB];
    logic [WIDTH-1:0] a_nx [NB];
    logic [WIDTH-1:0] b_nx [NB];
    logic [WIDTH-1:0] s_nx [NB];

    logic [BLOCK-1:0] sl_a [NB];
    logic [BLOCK-1:0] sl_b [NB];
    logic [BLOCK-1:0] sl_s [NB];
    logic             sl_ci[NB];
    logic             sl_co[NB];
`ifdef CSA_OVERFLOW_EN
    logic             sl_mc[NB];
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (Sub == OP_SUB) ? ~B : B;
    assign c0       = (Sub == OP_SUB) ? 1'b1 : Cin;

    // Pending operands shift down a slice per stage; finished sum bits
    // enter at the top so the full word is aligned at the last stage.
    for (genvar k = 0; k < NB; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign sl_a[k]  = A[BLOCK-1:0];
            assign sl_b[k]  = b_eff[BLOCK-1:0];
            assign sl_ci[k] = c0;
            assign a_nx[k]  = A >> BLOCK;
            assign b_nx[k]  = b_eff >> BLOCK;
            assign s_nx[k]  = WIDTH'(sl_s[k]) << (WIDTH - BLOCK);
            assign v_nx[k]  = in_valid;
        end else begin : g_body
            assign sl_a[k]  = a_q[k-1][BLOCK-1:0];
            assign sl_b[k]  = b_q[k-1][BLOCK-1:0];
            assign sl_ci[k] = c_q[k-1];
            assign a_nx[k]  = a_q[k-1] >> BLOCK;
            assign b_nx[k]  = b_q[k-1] >> BLOCK;
            assign s_nx[k]  = (s_q[k-1] >> BLOCK)
                            | (WIDTH'(sl_s[k]) << (WIDTH - BLOCK));
            assign v_nx[k]  = v_q[k-1];
        end

        csa_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .a   (sl_a[k]),
            .b   (sl_b[k]),
            .cin (sl_ci[k]),
            .sum (sl_s[k]),
            .cout(sl_co[k])
`ifdef CSA_OVERFLOW_EN
            ,
            .msb_cin(sl_mc[k])
`endif
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NB; k++) begin
                v_q[k] <= v_nx[k];
                c_q[k] <= sl_co[k];
                a_q[k] <= a_nx[k];
                b_q[k] <= b_nx[k];
                s_q[k] <= s_nx[k];
            end
        end
    end

    assign out_valid = v_q[NB-1];
    assign Sum       = s_q[NB-1];
    assign Carry     = c_q[NB-1];

`ifdef CSA_OVERFLOW_EN
    logic ov_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
        end else if (adv) begin
            ov_q <= sl_mc[NB-1] ^ sl_co[NB-1];
        end
    end

    assign Overflow = ov_q;
`endif

endmodule

// File: tb/tb_carry_select_adder_pipe.sv
// Bench for carry_select_adder_pipe: directed vectors plus an arithmetic
// reference model checked on every output cycle.
module tb_carry_select_adder_pipe;

    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NB    = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             Sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
`ifdef CSA_OVERFLOW_EN
    logic             Overflow;
`endif

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_out = 0;
    int n_flush = 0;

    typedef struct packed {
        logic             ov;
        logic             c;
        logic [WIDTH-1:0] s;
    } res_t;

    res_t q[$];

    logic             hold_act = 1'b0;
    logic [WIDTH-1:0] hold_s = '0;
    logic             hold_c = 1'b0;

    always #5 clk = ~clk;

    carry_select_adder_pipe #(
        .WIDTH(WIDTH),
        .BLOCK(BLOCK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Sub      (Sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum      (Sum),
        .Carry    (Carry)
`ifdef CSA_OVERFLOW_EN
        ,
        .Overflow (Overflow)
`endif
    );

    // Plain full-width arithmetic; overflow from operand/result signs.
    function automatic res_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        res_t             r;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub ? 1'b1 : cin);
        r.s  = full[WIDTH-1:0];
        r.c  = full[WIDTH];
        r.ov = (a[WIDTH-1] == bb[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n_flush += q.size();
            q.delete();
            hold_act = 1'b0;
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (hold_act) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(Sum), 32'(hold_s));
                chk("hold_carry", 32'(Carry), 32'(hold_c));
            end
            hold_act = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: sum %0h with none expected",
                             Sum);
                end else begin
                    chk("model_sum", 32'(Sum), 32'(q[0].s));
                    chk("model_carry", 32'(Carry), 32'(q[0].c));
`ifdef CSA_OVERFLOW_EN
                    chk("model_ovf", 32'(Overflow), 32'(q[0].ov));
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end else begin
                        hold_act = 1'b1;
                        hold_s   = Sum;
                        hold_c   = Carry;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, Cin, Sub));
                n_acc++;
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        in_valid = 1'b1;
        A = a;
        B = b;
        Cin = cin;
        Sub = sub;
    endtask

    // Present one operand set and hold it until an edge accepts it.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        logic acc;
        drive(a, b, cin, sub);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck %0b expected 1", in_ready);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        Sub = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic run_one(input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub,
                           input logic [WIDTH-1:0] es, input logic ec,
                           input logic eo, input string name);
        int lat;
        out_ready = 1'b1;
        drive(a, b, cin, sub);
        @(posedge clk);
        #1;
        idle();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(NB));
        chk({name, "_sum"}, 32'(Sum), 32'(es));
        chk({name, "_carry"}, 32'(Carry), 32'(ec));
`ifdef CSA_OVERFLOW_EN
        chk({name, "_ovf"}, 32'(Overflow), 32'(eo));
`else
        if (eo) begin end
`endif
        @(posedge clk);
        #1;
        chk({name, "_alone"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_carry", 32'(Carry), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef CSA_OVERFLOW_EN
        chk("rst_ovf", 32'(Overflow), 32'd0);
`endif
        rst = 1'b0;

        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
        run_one(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_pos");
        run_one(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "ripple");
        run_one(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, "add_cin");
        run_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_cin");
        run_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "all_ones");
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add");
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "ovf_sub");

        // Back-to-back stream: exactly one result retires per cycle.
        begin
            int acc0;
            acc0 = n_acc;
            out_ready = 1'b1;
            for (int i = 0; i < 100; i++) begin
                send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                     $urandom_range(0, 3) == 0);
            end
            idle();
            repeat (NB - 1) @(posedge clk);
            #1;
            chk("b2b_accepts", 32'(n_acc - acc0), 32'd100);
            chk("b2b_last_valid", 32'(out_valid), 32'd1);
            chk("b2b_pending", 32'(q.size()), 32'd1);
            wait_drain();
        end

        // Full pipe stalled for five cycles with a waiting input.
        out_ready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            send(16'h1111 * WIDTH'(i + 1), 16'h0F0F, 1'b1, 1'b0);
        end
        drive(16'hABCD, 16'h1234, 1'b0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        send(16'hABCD, 16'h1234, 1'b0, 1'b1);
        idle();
        wait_drain();

        // Reset with three results in flight.
        out_ready = 1'b1;
        send(16'h0102, 16'h0304, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b1, 1'b0);
        send(16'h4444, 16'h0404, 1'b0, 1'b1);
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(Sum), 32'd0);
        chk("midrst_carry", 32'(Carry), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_one(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");
        repeat (NB) @(posedge clk);
        #1;
        chk("post_rst_quiet", 32'(out_valid), 32'd0);

        chk("final_queue", 32'(q.size()), 32'd0);
        chk("acc_vs_out", 32'(n_acc), 32'(n_out + n_flush));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t limit 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/carry_select_adder_pipe.md
# carry_select_adder_pipe

Parametrised, pipelined carry-select adder/subtractor. Splits WIDTH-bit operands into BLOCK-bit slices; each slice precomputes sum/carry for carry-in 0 and 1 and a 2:1 select picks the result from the incoming carry. One register stage per slice gives one result per cycle at fixed latency. This is the datapath-level successor to the 1-bit sum/carry select multiplexer, with width, block size, subtract mode and a valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of BLOCK.
- BLOCK, 4, slice width; NUM_BLOCKS = WIDTH/BLOCK, at least 1.

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add mode only)
- Sub  input  1  1 = A - B, 0 = A + B + Cin
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- Sum  output  WIDTH  result
- Carry  output  1  carry-out of MSB slice (add: carry, sub: 1 = no borrow)
- Overflow  output  1  signed overflow (only with CSA_OVERFLOW_EN)

## Operation
- Sub=1: slice operands use ~B, carry into slice 0 forced to 1; Cin ignored.
- Slice k, stage k: computes {c,s} = A_k + B_k + 0 and A_k + B_k + 1; selects by carry registered from slice k-1 (slice 0: effective Cin).
- Operand skew: slices k+1..N-1 carried forward through registers; finished slices delayed so all Sum bits leave together.
- Result arithmetic: Sum = (A + B' + c0) mod 2^WIDTH, Carry = bit WIDTH of the full-width sum, exact for all inputs.
- Global advance: adv = !out_valid || out_ready. All pipeline registers, including per-stage valid bits, load only when adv=1.
- in_ready = adv; transfer occurs when in_valid && in_ready. Stage-0 valid loads in_valid && adv.
- Bubbles are not collapsed; a stalled pipeline holds every stage unchanged.
- Sum/Carry/Overflow hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (asynchronous assert, synchronous-edge release): all valid bits 0, out_valid=0, Sum=0, Carry=0, Overflow=0; in_ready=1 one cycle-free (combinational) after reset.
- Latency: operands accepted on edge t appear with out_valid=1 after edge t+NUM_BLOCKS-1 (NUM_BLOCKS register stages, first stage is the accept edge).
- Throughput: one result per cycle while out_ready=1.
- in_ready combinationally depends on out_ready and out_valid; no other combinational input-to-output paths.
- Simultaneous accept and drain with full pipe: allowed, no bubble.
- Reset mid-operation discards all in-flight results; no partial output.

## Configuration
- CSA_OVERFLOW_EN defined: Overflow port present; Overflow = carry into MSB XOR carry out of MSB, registered and aligned with Sum; MSB slice also propagates carry into its top bit.
- Not defined: Overflow port and its logic absent; everything else identical.

## Structure
- Package csa_pkg: localparam helper for NUM_BLOCKS, op encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module csa_block: BLOCK-bit combinational slice, inputs a, b, cin, outputs sum, cout (and MSB carry-in for overflow); two internal ripple adds plus select mux.
- Top instantiates NUM_BLOCKS csa_block in a generate loop with the skew/deskew registers and valid chain.

## Test plan
- WIDTH=16, BLOCK=4: A=0xFFFF, B=0x0001, Cin=0, Sub=0 -> after 4 cycles Sum=0x0000, Carry=1.
- Sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, Carry=0; A=0x0007, B=0x0005 -> Sum=0x0002, Carry=1.
- CSA_OVERFLOW_EN: A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x8000, Overflow=1; A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Overflow=1.
- Back-to-back 100 random operand pairs, out_ready=1 -> one result per cycle, matching A+B+Cin in order.
- out_ready held 0 for 5 cycles with full pipe -> in_ready=0, Sum/Carry stable, no result lost or duplicated on release.
- Assert rst with 3 results in flight -> out_valid=0, Sum=0 immediately; first post-reset input emerges alone after 4 cycles.
